// File: rtl/fb_rect_writer_if.sv
// Command and block-RAM write bundle for fb_rect_writer.
// The master issues rectangle commands; the slave (the engine) drives the write port and status.
interface fb_rect_writer_if #(
    parameter int COORD_W = 8,
    parameter int SIZE_W  = 9,
    parameter int COLOR_W = 15
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [COORD_W-1:0]   cmd_x;
    logic [COORD_W-1:0]   cmd_y;
    logic [SIZE_W-1:0]    cmd_w;
    logic [SIZE_W-1:0]    cmd_h;
    logic [COLOR_W-1:0]   cmd_color;
    logic [2*COORD_W-1:0] wr_address;
    logic [COLOR_W-1:0]   wr_data;
    logic                 wr_en;
    logic                 busy;
    logic                 done;

    // Handshake: a command transfers on a rising clock edge where cmd_valid and cmd_ready
    // are both high. cmd_ready is registered and depends only on engine state, never on
    // cmd_valid. Command fields are sampled only on the transfer edge.
    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, wr_address, wr_data, wr_en, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, wr_address, wr_data, wr_en, busy, done
    );
endinterface

// File: rtl/fb_rect_writer.sv
// Rectangle-fill write engine for the 256x256 RGB555 scan-out framebuffer, addresses {col,row}.
// Optional FB_VBLANK_GATE_EN restricts writes to cycles where the synchronized vblank is high.
module fb_rect_writer #(
    parameter int COORD_W = 8,
    parameter int SIZE_W  = 9,
    parameter int COLOR_W = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            vblank,
    fb_rect_writer_if.slave bus,
    output logic [1:0]      debug_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [SIZE_W-1:0] MAX_SPAN = SIZE_W'(1) << COORD_W;

    state_t state, state_n;

    logic [COORD_W-1:0]   x_q, y_q, w_m1, h_m1, cx, cy;
    logic [COORD_W-1:0]   x_n, y_n, w_m1_n, h_m1_n, cx_n, cy_n;
    logic [COLOR_W-1:0]   color_q, color_n;
    logic [2*COORD_W-1:0] addr_q, addr_n;
    logic [COLOR_W-1:0]   data_q, data_n;
    logic                 wr_en_q, wr_en_n;
    logic                 done_q, done_n;
    logic                 busy_q, busy_n;
    logic                 ready_q, ready_n;
    logic [COORD_W-1:0]   col_n, row_n;
    logic [SIZE_W-1:0]    w_span, h_span;
    logic                 accept;
    logic                 last_pixel;
    logic                 write_ok;

`ifdef FB_VBLANK_GATE_EN
    logic [1:0] vblank_sync;

    always_ff @(posedge clock) begin
        if (!reset) begin
            vblank_sync <= '0;
        end else begin
            vblank_sync <= {vblank_sync[0], vblank};
        end
    end

    assign write_ok = vblank_sync[1];
`else
    logic unused_vblank;

    assign unused_vblank = vblank;
    assign write_ok      = 1'b1;
`endif

    // Spans above 256 collapse to a full axis; stored as span-1 so 256 fits in COORD_W bits.
    assign w_span     = (bus.cmd_w > MAX_SPAN) ? MAX_SPAN : bus.cmd_w;
    assign h_span     = (bus.cmd_h > MAX_SPAN) ? MAX_SPAN : bus.cmd_h;
    assign accept     = bus.cmd_valid && ready_q;
    assign last_pixel = (cx == w_m1) && (cy == h_m1);

    // The output registers always present pixel (cx,cy); wr_en_q says it is written this cycle.
    always_comb begin
        state_n = state;
        x_n     = x_q;
        y_n     = y_q;
        w_m1_n  = w_m1;
        h_m1_n  = h_m1;
        color_n = color_q;
        cx_n    = cx;
        cy_n    = cy;
        addr_n  = addr_q;
        data_n  = data_q;
        wr_en_n = 1'b0;
        done_n  = 1'b0;
        busy_n  = 1'b1;
        ready_n = 1'b0;
        col_n   = '0;
        row_n   = '0;

        unique case (state)
            IDLE: begin
                busy_n  = 1'b0;
                ready_n = 1'b1;
                if (accept) begin
                    x_n     = bus.cmd_x;
                    y_n     = bus.cmd_y;
                    w_m1_n  = COORD_W'(w_span - SIZE_W'(1));
                    h_m1_n  = COORD_W'(h_span - SIZE_W'(1));
                    color_n = bus.cmd_color;
                    cx_n    = '0;
                    cy_n    = '0;
                    busy_n  = 1'b1;
                    ready_n = 1'b0;
                    if (bus.cmd_w == '0 || bus.cmd_h == '0) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = FILL;
                        wr_en_n = write_ok;
                        addr_n  = {bus.cmd_x, bus.cmd_y};
                        data_n  = bus.cmd_color;
                    end
                end
            end
            FILL: begin
                wr_en_n = write_ok;
                if (wr_en_q) begin
                    if (last_pixel) begin
                        state_n = DONE;
                        wr_en_n = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        if (cx == w_m1) begin
                            cx_n = '0;
                            cy_n = cy + COORD_W'(1);
                        end else begin
                            cx_n = cx + COORD_W'(1);
                        end
                        // Coordinates wrap per axis by plain COORD_W-bit addition.
                        col_n  = x_q + cx_n;
                        row_n  = y_q + cy_n;
                        addr_n = {col_n, row_n};
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                ready_n = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_m1    <= '0;
            h_m1    <= '0;
            color_q <= '0;
            cx      <= '0;
            cy      <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_n;
            x_q     <= x_n;
            y_q     <= y_n;
            w_m1    <= w_m1_n;
            h_m1    <= h_m1_n;
            color_q <= color_n;
            cx      <= cx_n;
            cy      <= cy_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            wr_en_q <= wr_en_n;
            done_q  <= done_n;
            busy_q  <= busy_n;
            ready_q <= ready_n;
        end
    end

    assign bus.cmd_ready  = ready_q;
    assign bus.wr_address = addr_q;
    assign bus.wr_data    = data_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign debug_state    = state;
endmodule

// File: tb/tb_fb_rect_writer.sv
// Bench for fb_rect_writer: vector table, directed multi-cycle sequences and random commands
// compared against a raster-order model of the rectangle fill.
module tb_fb_rect_writer;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       vblank = 1'b0;
    logic [1:0] debug_state;

    fb_rect_writer_if #(.COORD_W(8), .SIZE_W(9), .COLOR_W(15)) bus ();

    fb_rect_writer #(.COORD_W(8), .SIZE_W(9), .COLOR_W(15)) dut (
        .clock       (clock),
        .reset       (reset),
        .vblank      (vblank),
        .bus         (bus),
        .debug_state (debug_state)
    );

    // ---------------- clock / cycle counter / vblank ----------------
    always #5 clock = ~clock;

    int         cyc = 0;
    logic [2:0] vb_h = 3'b000;

    always @(posedge clock) begin
        cyc  <= cyc + 1;
        vb_h <= {vb_h[1:0], vblank};
    end

    initial begin
        forever begin
            repeat (5) @(negedge clock);
            vblank = ~vblank;
        end
    end

    // ---------------- scoreboard state ----------------
    logic [30:0] exp_q[$];
    logic [30:0] act_q[$];
    int          wr_cyc_q[$];
    int          done_cyc_q[$];
    int          inv_bad = 0;
    int          ready_hi_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    bit          hit_map [0:65535];

    // Monitor: record every write and done pulse, and count protocol invariant breaks.
    always @(negedge clock) begin
        if (reset) begin
            if (bus.wr_en) begin
                act_q.push_back({bus.wr_address, bus.wr_data});
                wr_cyc_q.push_back(cyc);
                if (bus.cmd_ready || !bus.busy || bus.done) inv_bad++;
`ifdef FB_VBLANK_GATE_EN
                if (!vb_h[2]) inv_bad++;
`endif
            end
            if (bus.done) begin
                done_cyc_q.push_back(cyc);
                if (bus.cmd_ready || !bus.busy) inv_bad++;
            end
            if (bus.cmd_ready) ready_hi_cnt++;
            if (bus.cmd_ready == bus.busy) inv_bad++;
        end
    end

    task automatic check(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        act_q.delete();
        wr_cyc_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic drive_cmd(input int x, input int y, input int w, input int h,
                             input logic [14:0] color);
        bus.cmd_valid = 1'b1;
        bus.cmd_x     = 8'(x);
        bus.cmd_y     = 8'(y);
        bus.cmd_w     = 9'(w);
        bus.cmd_h     = 9'(h);
        bus.cmd_color = color;
    endtask

    // ---------------- driver + model + per-command checks ----------------
    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [14:0] color, input string name, input bit scramble);
        int ws, hs, n, waited, acc, bad, bad_i;
        ws = (w > 256) ? 256 : w;
        hs = (h > 256) ? 256 : h;
        n  = ws * hs;
        clear_sb();
        for (int r = 0; r < hs; r++)
            for (int c = 0; c < ws; c++)
                exp_q.push_back({8'((x + c) % 256), 8'((y + r) % 256), color});

        @(negedge clock);
        waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check(bus.cmd_ready === 1'b1, {name, "_ready_before"},
              $sformatf("cmd_ready=%b want 1", bus.cmd_ready));
        drive_cmd(x, y, w, h, color);
        acc = cyc;
        @(posedge clock);
        #1;
        inv_bad      = 0;
        ready_hi_cnt = 0;
        bus.cmd_valid = 1'b0;
        if (scramble) begin
            bus.cmd_x     = 8'($urandom);
            bus.cmd_y     = 8'($urandom);
            bus.cmd_w     = 9'($urandom);
            bus.cmd_h     = 9'($urandom);
            bus.cmd_color = 15'($urandom);
        end

        waited = 0;
        while (done_cyc_q.size() == 0 && waited < 4 * n + 40) begin
            @(posedge clock);
            waited++;
        end
        check(done_cyc_q.size() > 0, {name, "_done_seen"},
              $sformatf("no done within %0d cycles", waited));
        check(ready_hi_cnt == 0, {name, "_ready_low"},
              $sformatf("cmd_ready high in %0d busy cycles want 0", ready_hi_cnt));
        @(negedge clock);
        #1;
        check(bus.cmd_ready === 1'b1 && bus.busy === 1'b0, {name, "_idle_after"},
              $sformatf("cmd_ready=%b busy=%b want 1 0", bus.cmd_ready, bus.busy));
        repeat (2) @(negedge clock);
        #1;
        check(done_cyc_q.size() == 1, {name, "_done_once"},
              $sformatf("done pulses=%0d want 1", done_cyc_q.size()));
        check(act_q.size() == n, {name, "_count"},
              $sformatf("writes=%0d want %0d", act_q.size(), n));
        bad = -1;
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            if (act_q[i] !== exp_q[i]) begin
                bad = i;
                break;
            end
        end
        bad_i = (bad < 0) ? 0 : bad;
        check(bad < 0, {name, "_order"},
              $sformatf("write %0d got %h want %h", bad, act_q[bad_i], exp_q[bad_i]));
        check(inv_bad == 0, {name, "_invariants"},
              $sformatf("protocol breaks=%0d want 0", inv_bad));
`ifndef FB_VBLANK_GATE_EN
        check(done_cyc_q.size() > 0 && done_cyc_q[0] - acc == n + 1, {name, "_done_latency"},
              $sformatf("done at %0d want %0d", done_cyc_q.size() > 0 ? done_cyc_q[0] - acc : -1, n + 1));
        if (n > 0)
            check(wr_cyc_q.size() > 0 && wr_cyc_q[0] - acc == 1 && wr_cyc_q[$] - acc == n,
                  {name, "_write_window"},
                  $sformatf("first=%0d last=%0d want 1 %0d",
                            wr_cyc_q.size() > 0 ? wr_cyc_q[0] - acc : -1,
                            wr_cyc_q.size() > 0 ? wr_cyc_q[$] - acc : -1, n));
`else
        if (n > 0)
            check(done_cyc_q.size() > 0 && wr_cyc_q.size() > 0 && done_cyc_q[0] == wr_cyc_q[$] + 1,
                  {name, "_done_after_last"}, "done not in cycle after final write");
        else
            check(done_cyc_q.size() > 0 && done_cyc_q[0] - acc == 1, {name, "_done_latency"},
                  "zero-size done not one cycle after acceptance");
`endif
    endtask

    // ---------------- table ----------------
    typedef struct {
        int          x, y, w, h;
        logic [14:0] color;
        int          exp_n;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int   acc;
        int   waited;
        int   uniq, dups, side;
        logic [15:0] last_exp;

        vecs[0] = '{x:10,  y:20,  w:1,   h:1,   color:15'h7C00, exp_n:1,   exp_first:16'h0A14, exp_last:16'h0A14};
        vecs[1] = '{x:5,   y:5,   w:3,   h:2,   color:15'h03E0, exp_n:6,   exp_first:16'h0505, exp_last:16'h0706};
        vecs[2] = '{x:254, y:255, w:4,   h:2,   color:15'h001F, exp_n:8,   exp_first:16'hFEFF, exp_last:16'h0100};
        vecs[3] = '{x:0,   y:0,   w:0,   h:7,   color:15'h1111, exp_n:0,   exp_first:16'h0000, exp_last:16'h0000};
        vecs[4] = '{x:9,   y:9,   w:5,   h:0,   color:15'h2222, exp_n:0,   exp_first:16'h0000, exp_last:16'h0000};
        vecs[5] = '{x:3,   y:9,   w:300, h:1,   color:15'h5555, exp_n:256, exp_first:16'h0309, exp_last:16'h0209};
        vecs[6] = '{x:0,   y:128, w:1,   h:300, color:15'h2AAA, exp_n:256, exp_first:16'h0080, exp_last:16'h007F};

        bus.cmd_valid = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_color = '0;

        // Reset held low for two edges; outputs must show their reset values.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check(bus.wr_en === 1'b0, "reset_wr_en", $sformatf("got %b want 0", bus.wr_en));
        check(bus.wr_address === 16'h0, "reset_wr_address", $sformatf("got %h want 0000", bus.wr_address));
        check(bus.wr_data === 15'h0, "reset_wr_data", $sformatf("got %h want 0000", bus.wr_data));
        check(bus.done === 1'b0, "reset_done", $sformatf("got %b want 0", bus.done));
        check(bus.busy === 1'b0, "reset_busy", $sformatf("got %b want 0", bus.busy));
        check(bus.cmd_ready === 1'b1, "reset_cmd_ready", $sformatf("got %b want 1", bus.cmd_ready));
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_cmd(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].color,
                    $sformatf("vec%0d", i), 1'b1);
            check(act_q.size() == vecs[i].exp_n, $sformatf("vec%0d_table_count", i),
                  $sformatf("writes=%0d want %0d", act_q.size(), vecs[i].exp_n));
            if (vecs[i].exp_n > 0)
                check(act_q[0][30:15] == vecs[i].exp_first && act_q[$][30:15] == vecs[i].exp_last
                      && act_q[0][14:0] == vecs[i].color,
                      $sformatf("vec%0d_table_ends", i),
                      $sformatf("first=%h last=%h data=%h want %h %h %h", act_q[0][30:15],
                                act_q[$][30:15], act_q[0][14:0], vecs[i].exp_first,
                                vecs[i].exp_last, vecs[i].color));
        end

        // Reset during write 3 of a 4x4 fill aborts it.
        clear_sb();
        @(negedge clock);
        drive_cmd(40, 60, 4, 4, 15'h0F0F);
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        waited = 0;
        while (act_q.size() < 3 && waited < 200) begin
            @(negedge clock);
            #1;
            waited++;
        end
        check(act_q.size() == 3, "abort_reach_write3", $sformatf("writes=%0d want 3", act_q.size()));
        reset = 1'b0;
        @(negedge clock);
        #1;
        check(bus.wr_en === 1'b0 && bus.cmd_ready === 1'b1 && bus.busy === 1'b0 && bus.done === 1'b0,
              "abort_state", $sformatf("wr_en=%b cmd_ready=%b busy=%b done=%b want 0 1 0 0",
                                       bus.wr_en, bus.cmd_ready, bus.busy, bus.done));
        reset = 1'b1;
        repeat (4) @(negedge clock);
        #1;
        check(act_q.size() == 3, "abort_no_more_writes", $sformatf("writes=%0d want 3", act_q.size()));
        run_cmd(7, 8, 2, 3, 15'h4321, "after_abort", 1'b0);

`ifndef FB_VBLANK_GATE_EN
        // cmd_valid held high: a 2x2 command is accepted every 6 cycles.
        clear_sb();
        @(negedge clock);
        drive_cmd(100, 50, 2, 2, 15'h1234);
        acc = cyc;
        repeat (13) @(negedge clock);
        bus.cmd_valid = 1'b0;
        repeat (10) @(negedge clock);
        #1;
        check(act_q.size() == 12, "b2b_count", $sformatf("writes=%0d want 12", act_q.size()));
        check(done_cyc_q.size() == 3, "b2b_done", $sformatf("done pulses=%0d want 3", done_cyc_q.size()));
        check(wr_cyc_q.size() == 12 && wr_cyc_q[0] - acc == 1 && wr_cyc_q[4] - wr_cyc_q[0] == 6
              && wr_cyc_q[8] - wr_cyc_q[4] == 6, "b2b_spacing",
              $sformatf("first write starts %0d %0d %0d want 1 7 13",
                        wr_cyc_q.size() > 0 ? wr_cyc_q[0] - acc : -1,
                        wr_cyc_q.size() > 4 ? wr_cyc_q[4] - acc : -1,
                        wr_cyc_q.size() > 8 ? wr_cyc_q[8] - acc : -1));
        side = 256;
`else
        side = 64;
`endif

        // Full-area fill: every address written once, ending at the bottom-right corner.
        run_cmd(0, 0, side, side, 15'h3DEF, "full", 1'b0);
        foreach (hit_map[i]) hit_map[i] = 1'b0;
        uniq = 0;
        dups = 0;
        foreach (act_q[i]) begin
            if (hit_map[act_q[i][30:15]]) dups++;
            else begin
                hit_map[act_q[i][30:15]] = 1'b1;
                uniq++;
            end
        end
        check(uniq == side * side && dups == 0, "full_coverage",
              $sformatf("distinct=%0d repeats=%0d want %0d 0", uniq, dups, side * side));
        last_exp = {8'(side - 1), 8'(side - 1)};
        check(act_q.size() > 0 && act_q[$][30:15] == last_exp, "full_last_address",
              $sformatf("got %h want %h", act_q.size() > 0 ? act_q[$][30:15] : 16'h0, last_exp));

        // Random commands, mostly small with occasional clamped spans.
        for (int k = 0; k < 24; k++) begin
            int rx, ry, rw, rh;
            rx = $urandom_range(0, 255);
            ry = $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) begin
                rw = $urandom_range(250, 300);
                rh = $urandom_range(1, 2);
            end else begin
                rw = $urandom_range(0, 9);
                rh = $urandom_range(0, 9);
            end
            run_cmd(rx, ry, rw, rh, 15'($urandom), $sformatf("rand%0d", k), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000000;
        checks++;
        failures++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
